// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Holds the serialiser state encoding, parity-mode constants and the
// bit-period calculation used to size the baud counter.
package uart_pkg;

  localparam int unsigned BPS_CNT_W = 16;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-stream handshake into the UART transmitter.
//   s_valid : producer has a byte on s_data
//   s_ready : transmitter can accept a byte this cycle
//   s_data  : byte to send
interface uart_tx_cfg_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO buffering bytes ahead of the serialiser.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset (flushes)
//   push_i, wdata_i  : write strobe and data (ignored when full)
//   pop_i, rdata_o   : read strobe and head-of-queue data (show-ahead)
//   full_o, empty_o  : occupancy flags
//   count_o          : current number of stored entries
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_c, pop_c;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO never accepts, even when a pop frees a slot that cycle.
  assign push_c = push_i && !full_o;
  assign pop_c  = pop_i && !empty_o;

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered byte input, serialised as
// start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   s_if             : byte handshake (slave side)
//   uart_txd         : registered serial line, idle high
//   tx_busy          : frame in progress or bytes still queued
//   fifo_count       : current FIFO occupancy
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 30_000_000,
  parameter int unsigned UART_BPS   = 128000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  uart_tx_cfg_if.slave                 s_if,
  output logic                         uart_txd,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BPS_CNT_W-1:0] BPS_LAST  = BPS_CNT_W'(BPS_CNT - 1);
  localparam logic [2:0]           DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]           STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]           DATA_MASK = 8'((1 << DATA_BITS) - 1);

  tx_state_e            state_q, state_d;
  logic [BPS_CNT_W-1:0] bps_cnt_q, bps_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;

  logic                 fifo_full, fifo_empty;
  logic [7:0]           fifo_rdata;
  logic [7:0]           head_masked;
  logic                 push_c, pop_c, bit_done;
  logic [CW-1:0]        cnt_nxt;

  assign s_if.s_ready = !fifo_full;
  assign push_c       = s_if.s_valid && s_if.s_ready;
  assign bit_done     = (bps_cnt_q == BPS_LAST);
  assign head_masked  = fifo_rdata & DATA_MASK;
  assign cnt_nxt      = fifo_count + CW'(push_c) - CW'(pop_c);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push_i  (push_c),
    .wdata_i (s_if.s_data),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Serialiser next-state, counters and line level.
  always_comb begin
    state_d   = state_q;
    bps_cnt_d = bps_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop_c     = 1'b0;
    txd_d     = 1'b1;
    busy_d    = 1'b0;

    // Bit-period counter idles at zero and wraps at each bit boundary.
    if (state_q == ST_IDLE) bps_cnt_d = '0;
    else if (bit_done)      bps_cnt_d = '0;
    else                    bps_cnt_d = bps_cnt_q + BPS_CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          state_d   = ST_START;
          bit_idx_d = '0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PAR: begin
        if (bit_done) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            // Chain straight into the next frame when bytes are waiting.
            if (!fifo_empty) begin
              pop_c   = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture the popped byte and its parity for the upcoming frame.
    if (pop_c) begin
      shift_d = head_masked;
      par_d   = (PARITY == PAR_ODD) ? ~(^head_masked) : ^head_masked;
    end

    // Line follows the current state, so it lags the FSM by one cycle.
    case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      ST_PAR:   txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE) || (cnt_nxt != '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      bps_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bps_cnt_q <= bps_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1 depth 4, 8E1, 8O1, 7N2) at
// 30 MHz / 128000 baud. Expected bytes/parity go into a scoreboard queue when
// driven and are compared against frames decoded from the serial line.
module tb_uart_tx_cfg;

  localparam int BPS = 234;

  logic       sys_clk;
  logic       sys_rst;
  logic       txd_a, txd_b, txd_c, txd_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b, cnt_c, cnt_d;

  uart_tx_cfg_if if_a ();
  uart_tx_cfg_if if_b ();
  uart_tx_cfg_if if_c ();
  uart_tx_cfg_if if_d ();

  uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_if(if_a),
    .uart_txd(txd_a), .tx_busy(busy_a), .fifo_count(cnt_a));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_if(if_b),
    .uart_txd(txd_b), .tx_busy(busy_b), .fifo_count(cnt_b));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_c (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_if(if_c),
    .uart_txd(txd_c), .tx_busy(busy_c), .fifo_count(cnt_c));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_d (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_if(if_d),
    .uart_txd(txd_d), .tx_busy(busy_d), .fifo_count(cnt_d));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         n;
    logic [7:0] din;
    int         nbits;
    int         npar;
    int         nstop;
    logic [7:0] exp_d;
    logic       exp_p;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic logic txd_of(input int n);
    case (n)
      0: return txd_a;
      1: return txd_b;
      2: return txd_c;
      default: return txd_d;
    endcase
  endfunction

  function automatic logic busy_of(input int n);
    case (n)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  function automatic int cnt_of(input int n);
    case (n)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      2: return int'(cnt_c);
      default: return int'(cnt_d);
    endcase
  endfunction

  function automatic logic rdy_of(input int n);
    case (n)
      0: return if_a.s_ready;
      1: return if_b.s_ready;
      2: return if_c.s_ready;
      default: return if_d.s_ready;
    endcase
  endfunction

  task automatic set_in(input int n, input logic v, input logic [7:0] d);
    case (n)
      0: begin if_a.s_valid = v; if_a.s_data = d; end
      1: begin if_b.s_valid = v; if_b.s_data = d; end
      2: begin if_c.s_valid = v; if_c.s_data = d; end
      default: begin if_d.s_valid = v; if_d.s_data = d; end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decode one frame; entered at the negedge showing the first start-bit cycle,
  // leaves at the negedge just after the frame. Every bit must hold for BPS cycles.
  task automatic rx_frame(input int n, input int nbits, input int npar, input int nstop,
                          output logic [7:0] d, output logic p,
                          output logic start_ok, output logic stop_ok, output logic stable_ok,
                          output logic b_pen, output logic b_last);
    int   total;
    logic lvl;
    total = 1 + nbits + npar + nstop;
    d = '0; p = 1'b0; start_ok = 1'b1; stop_ok = 1'b1; stable_ok = 1'b1;
    b_pen = 1'b0; b_last = 1'b0;
    for (int b = 0; b < total; b++) begin
      lvl = txd_of(n);
      for (int c = 0; c < BPS; c++) begin
        if (txd_of(n) !== lvl) stable_ok = 1'b0;
        if (b == total - 1 && c == BPS - 2) b_pen  = busy_of(n);
        if (b == total - 1 && c == BPS - 1) b_last = busy_of(n);
        @(negedge sys_clk);
      end
      if (b == 0)                             start_ok = (lvl == 1'b0);
      else if (b <= nbits)                    d[b-1] = lvl;
      else if (npar != 0 && b == nbits + 1)   p = lvl;
      else if (lvl !== 1'b1)                  stop_ok = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       rp, s_ok, p_ok, st_ok, bpen, blast;
    exp_t       e;
    logic [7:0] seq[6];

    vecs[0] = '{0, 8'h55, 8, 0, 1, 8'h55, 1'b0};
    vecs[1] = '{1, 8'hA5, 8, 1, 1, 8'hA5, 1'b0};
    vecs[2] = '{2, 8'hA5, 8, 1, 1, 8'hA5, 1'b1};
    vecs[3] = '{3, 8'hFF, 7, 0, 2, 8'h7F, 1'b0};
    vecs[4] = '{1, 8'h07, 8, 1, 1, 8'h07, 1'b1};
    vecs[5] = '{2, 8'h07, 8, 1, 1, 8'h07, 1'b0};
    vecs[6] = '{3, 8'h80, 7, 0, 2, 8'h00, 1'b0};
    vecs[7] = '{0, 8'hC3, 8, 0, 1, 8'hC3, 1'b0};
    for (int i = 0; i < 6; i++) seq[i] = 8'(i + 1);

    for (int n = 0; n < 4; n++) set_in(n, 1'b0, 8'h00);
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("rst_txd[%0d]", n),   txd_of(n),  1);
      chk($sformatf("rst_busy[%0d]", n),  busy_of(n), 0);
      chk($sformatf("rst_count[%0d]", n), cnt_of(n),  0);
      chk($sformatf("rst_ready[%0d]", n), rdy_of(n),  1);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Single frames into idle instances.
    for (int v = 0; v < 8; v++) begin
      set_in(vecs[v].n, 1'b1, vecs[v].din);
      @(posedge sys_clk);
      e.d = vecs[v].exp_d; e.p = vecs[v].exp_p;
      exp_q.push_back(e);
      @(negedge sys_clk);
      set_in(vecs[v].n, 1'b0, ~vecs[v].din);
      chk($sformatf("v%0d_count_after_push", v), cnt_of(vecs[v].n), 1);
      chk($sformatf("v%0d_busy_after_push", v), busy_of(vecs[v].n), 1);
      @(negedge sys_clk);
      chk($sformatf("v%0d_txd_k1_high", v), txd_of(vecs[v].n), 1);
      @(negedge sys_clk);
      chk($sformatf("v%0d_txd_k2_low", v), txd_of(vecs[v].n), 0);
      rx_frame(vecs[v].n, vecs[v].nbits, vecs[v].npar, vecs[v].nstop,
               rd, rp, s_ok, p_ok, st_ok, bpen, blast);
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_scoreboard_empty", v), 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_data", v), rd, e.d);
        if (vecs[v].npar != 0) chk($sformatf("v%0d_parity", v), rp, e.p);
      end
      chk($sformatf("v%0d_start_bit", v), s_ok, 1);
      chk($sformatf("v%0d_stop_bits", v), p_ok, 1);
      chk($sformatf("v%0d_bit_periods", v), st_ok, 1);
      chk($sformatf("v%0d_busy_before_end", v), bpen, 1);
      chk($sformatf("v%0d_busy_fall", v), blast, 0);
      repeat (5) @(negedge sys_clk);
    end

    // Depth-4 FIFO held full by a streaming producer; frames must chain with no gap.
    fork
      begin : drv
        int   i, cyc, max_cnt, bad_rdy;
        logic acc, saw_full;
        exp_t ed;
        i = 0; cyc = 0; max_cnt = 0; bad_rdy = 0; saw_full = 1'b0;
        set_in(0, 1'b1, seq[0]);
        while (i < 6 && cyc < 4000) begin
          acc = rdy_of(0);
          @(posedge sys_clk);
          if (acc) begin
            ed.d = seq[i]; ed.p = 1'b0;
            exp_q.push_back(ed);
            i++;
          end
          @(negedge sys_clk);
          cyc++;
          if (cnt_of(0) > max_cnt) max_cnt = cnt_of(0);
          if (cnt_of(0) == 4) begin
            saw_full = 1'b1;
            if (rdy_of(0)) bad_rdy++;
          end
          if (i < 6) set_in(0, 1'b1, seq[i]);
          else       set_in(0, 1'b0, 8'h00);
        end
        chk("seq_all_accepted", i, 6);
        chk("seq_full_reached", saw_full, 1);
        chk("seq_max_count", max_cnt, 4);
        chk("seq_ready_low_when_full", bad_rdy, 0);
      end
      begin : rcv
        int   w;
        logic [7:0] sd;
        logic sp, sok, pok, stok, bp, bl;
        exp_t er;
        w = 0;
        while (txd_of(0) !== 1'b0 && w < 20) begin
          @(negedge sys_clk);
          w++;
        end
        chk("seq_first_start", txd_of(0), 0);
        for (int f = 0; f < 6; f++) begin
          if (f > 0) chk($sformatf("seq_zero_gap[%0d]", f), txd_of(0), 0);
          rx_frame(0, 8, 0, 1, sd, sp, sok, pok, stok, bp, bl);
          if (exp_q.size() == 0) begin
            chk($sformatf("seq_scoreboard_empty[%0d]", f), 1, 0);
          end else begin
            er = exp_q.pop_front();
            chk($sformatf("seq_data[%0d]", f), sd, er.d);
          end
          chk($sformatf("seq_stop[%0d]", f), pok, 1);
          chk($sformatf("seq_bit_periods[%0d]", f), stok, 1);
        end
        chk("seq_busy_fall", bl, 0);
        chk("seq_idle_after", txd_of(0), 1);
      end
    join

    // Reset in the middle of a data bit with two bytes still queued.
    repeat (5) @(negedge sys_clk);
    set_in(0, 1'b1, 8'h3C); @(posedge sys_clk); @(negedge sys_clk);
    set_in(0, 1'b1, 8'h11); @(posedge sys_clk); @(negedge sys_clk);
    set_in(0, 1'b1, 8'h22); @(posedge sys_clk); @(negedge sys_clk);
    set_in(0, 1'b0, 8'h00);
    repeat (BPS + 100) @(negedge sys_clk);
    chk("rst_mid_data_low", txd_of(0), 0);
    chk("rst_mid_queued", cnt_of(0), 2);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_mid_txd", txd_of(0), 1);
    chk("rst_mid_count", cnt_of(0), 0);
    chk("rst_mid_busy", busy_of(0), 0);
    chk("rst_mid_ready", rdy_of(0), 1);
    begin
      int lows, busys;
      lows = 0; busys = 0;
      for (int c = 0; c < 3 * 10 * BPS; c++) begin
        @(negedge sys_clk);
        if (txd_of(0) !== 1'b1) lows++;
        if (busy_of(0) !== 1'b0) busys++;
      end
      chk("rst_no_more_frames", lows, 0);
      chk("rst_stays_idle", busys, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 30_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 128000, baud rate; BPS_CNT = CLK_FREQ/UART_BPS cycles per bit (integer division).
REQ-003 Parameter DATA_BITS, default 8, legal 5..8, data bits per frame.
REQ-004 Parameter PARITY, default 0, 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, power of two >= 2, transmit buffer entries.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 sys_clk  input  1  system clock, all logic on rising edge.
REQ-009 sys_rst  input  1  synchronous active-high reset.
REQ-010 s_valid  input  1  producer has a byte on s_data.
REQ-011 s_ready  output  1  block can accept a byte this cycle.
REQ-012 s_data  input  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-013 uart_txd  output  1  serial line, idle high, registered.
REQ-014 tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Byte accepted on a rising edge where s_valid && s_ready; s_ready = (fifo_count != FIFO_DEPTH), no push when full even if a pop occurs that cycle.
REQ-017 FSM states IDLE, START, DATA, PAR, STOP; IDLE->START when FIFO non-empty (pop that edge); START->DATA after BPS_CNT cycles; DATA->PAR (PARITY!=0) or STOP after DATA_BITS bit periods; PAR->STOP after BPS_CNT; STOP->START (FIFO non-empty, pop) or IDLE after STOP_BITS*BPS_CNT cycles.
REQ-018 Line levels: IDLE 1, START 0, DATA LSB first, PAR parity bit, STOP 1.
REQ-019 Every bit, including each stop bit, lasts exactly BPS_CNT cycles; no truncated stop bit.
REQ-020 Parity over the DATA_BITS transmitted bits: even -> XOR of bits; odd -> inverted XOR.
REQ-021 Latency: FIFO empty, FSM IDLE, byte accepted at edge k -> uart_txd low from edge k+2.
REQ-022 Back-to-back frames: next start bit begins immediately after the last stop bit period, zero idle cycles.
REQ-023 Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BPS_CNT cycles.
REQ-024 Bit-period counter: 16-bit, counts 0..BPS_CNT-1, wraps to 0; bit index counter resets on each state entry.
REQ-025 tx_busy falls on the same edge the FSM returns to IDLE with the FIFO empty.
REQ-026 s_data captured at push; later changes to s_data do not affect a queued byte.

Reset
REQ-027 On sys_rst high at an edge: FSM IDLE, counters 0, FIFO flushed, fifo_count 0, uart_txd 1, tx_busy 0, s_ready 1 after the edge.
REQ-028 Reset mid-frame aborts the frame; uart_txd is 1 from the reset edge; no partial byte is resumed.

Structure
REQ-029 Shared package uart_pkg holds FSM state enum, PARITY encoding constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the BPS_CNT calculation function.
REQ-030 Buffer is one sub-module uart_tx_fifo (synchronous, single clock, FIFO_DEPTH entries, full/empty/count); serialiser FSM lives in uart_tx_cfg.

Verification (CLK_FREQ 30_000_000, UART_BPS 128000 -> BPS_CNT 234)
REQ-031 8N1, push 0x55 into idle block -> txd low at k+2, bit pattern 0,1,0,1,0,1,0,1,0,1 each 234 cycles, 2340-cycle frame, tx_busy low after.
REQ-032 8E1 push 0xA5 -> parity bit 0; 8O1 push 0xA5 -> parity bit 1; frame 2574 cycles.
REQ-033 7N2 push 0xFF -> 7 data bits 1, two stop bits, frame 2340 cycles; bit 7 absent.
REQ-034 FIFO_DEPTH 4, hold s_valid for 6 bytes 0x01..0x06 -> s_ready low after stored count reaches 4, all 6 sent in order with zero gap between frames.
REQ-035 Assert sys_rst mid-DATA of frame 0x3C with 2 bytes queued -> txd 1 next edge, fifo_count 0, no further frames transmitted.
